sc_fifo_ex: RTL



---
 rtl/fifo_pkg.sv | 15 +
 rtl/dual_port_ram.sv | 24 ++
 rtl/sc_fifo_ex.sv | 111 +++++++++++
 3 files changed

// File: rtl/fifo_pkg.sv
// fifo_pkg: shared helpers for the FIFO family (pointer width, saturating counter increment).
package fifo_pkg;

    function automatic int ptr_width(input int addr_width);
        return addr_width + 1;
    endfunction

    // Holds at all-ones for a w-bit counter carried in a 32-bit container.
    function automatic logic [31:0] sat_inc(input logic [31:0] v, input int w);
        logic [31:0] ones;
        ones = (32'd1 << w) - 32'd1;
        return (v == ones) ? v : v + 32'd1;
    endfunction

endpackage

// File: rtl/dual_port_ram.sv
// dual_port_ram: simple dual-port RAM, independent write and registered-read ports.
module dual_port_ram #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 3
) (
    input  logic                  wr_clk_i,
    input  logic [DATA_WIDTH-1:0] wr_data_i,
    input  logic [ADDR_WIDTH-1:0] wr_addr_i,
    input  logic                  wr_i,
    input  logic                  rd_clk_i,
    input  logic [ADDR_WIDTH-1:0] rd_addr_i,
    input  logic                  rd_i,
    output logic [DATA_WIDTH-1:0] rd_data_o
);
    logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];

    always_ff @(posedge wr_clk_i)
        if (wr_i)
            mem[wr_addr_i] <= wr_data_i;

    always_ff @(posedge rd_clk_i)
        if (rd_i)
            rd_data_o <= mem[rd_addr_i];
endmodule

// File: rtl/sc_fifo_ex.sv
// sc_fifo_ex: single-clock show-ahead FIFO with programmable levels, flush and sticky flags.
// Optional drop counters enabled by defining SC_FIFO_EX_STAT_EN.
module sc_fifo_ex
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH   = 8,
    parameter int WORDS_AMOUNT = 8,
    parameter int ADDR_WIDTH   = $clog2(WORDS_AMOUNT),
    parameter int STAT_WIDTH   = 16
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic [DATA_WIDTH-1:0] wr_data_i,
    input  logic                  wr_i,
    input  logic                  rd_i,
    output logic [DATA_WIDTH-1:0] rd_data_o,
    input  logic                  flush_i,
    input  logic [ADDR_WIDTH:0]   af_level_i,
    input  logic [ADDR_WIDTH:0]   ae_level_i,
    input  logic                  clr_flags_i,
    output logic [ADDR_WIDTH:0]   used_words_o,
    output logic                  full_o,
    output logic                  empty_o,
    output logic                  almost_full_o,
    output logic                  almost_empty_o,
    output logic                  ovf_o,
    output logic                  udf_o
`ifdef SC_FIFO_EX_STAT_EN
    ,
    output logic [STAT_WIDTH-1:0] wr_drop_cnt_o,
    output logic [STAT_WIDTH-1:0] rd_drop_cnt_o
`endif
);
    localparam int PW = ptr_width(ADDR_WIDTH);

    logic [PW-1:0] wr_ptr, rd_ptr, used;
    logic          data_at_output, data_in_mem, rd_en;
    logic          wr_req, rd_req, wr_rej, rd_rej;

    // Flush swallows the cycle's requests, so neither acceptance nor rejection is seen.
    assign wr_req      = wr_i && !full_o && !flush_i;
    assign rd_req      = rd_i && !empty_o && !flush_i;
    assign wr_rej      = wr_i && full_o && !flush_i;
    assign rd_rej      = rd_i && empty_o && !flush_i;
    assign data_in_mem = wr_ptr != rd_ptr;
    assign rd_en       = data_in_mem && (!data_at_output || rd_req);

    assign used_words_o   = used;
    assign full_o         = used == PW'(WORDS_AMOUNT);
    assign empty_o        = !data_at_output;
    assign almost_full_o  = used >= af_level_i;
    assign almost_empty_o = used <= ae_level_i;

    always_ff @(posedge clk_i) begin
        if (rst_i || flush_i) begin
            wr_ptr         <= '0;
            rd_ptr         <= '0;
            used           <= '0;
            data_at_output <= 1'b0;
        end else begin
            if (wr_req)
                wr_ptr <= wr_ptr + PW'(1);
            if (rd_en)
                rd_ptr <= rd_ptr + PW'(1);
            if (rd_req || !data_at_output)
                data_at_output <= data_in_mem;
            used <= used + PW'(wr_req) - PW'(rd_req);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ovf_o <= 1'b0;
            udf_o <= 1'b0;
        end else begin
            ovf_o <= wr_rej || (ovf_o && !clr_flags_i);
            udf_o <= rd_rej || (udf_o && !clr_flags_i);
        end
    end

`ifdef SC_FIFO_EX_STAT_EN
    always_ff @(posedge clk_i) begin
        if (rst_i || clr_flags_i) begin
            wr_drop_cnt_o <= '0;
            rd_drop_cnt_o <= '0;
        end else begin
            if (wr_rej)
                wr_drop_cnt_o <= STAT_WIDTH'(sat_inc(32'(wr_drop_cnt_o), STAT_WIDTH));
            if (rd_rej)
                rd_drop_cnt_o <= STAT_WIDTH'(sat_inc(32'(rd_drop_cnt_o), STAT_WIDTH));
        end
    end
`else
    logic [STAT_WIDTH-1:0] unused_stat;
    assign unused_stat = '0;
`endif

    dual_port_ram #(
        .DATA_WIDTH(DATA_WIDTH),
        .ADDR_WIDTH(ADDR_WIDTH)
    ) u_ram (
        .wr_clk_i (clk_i),
        .wr_data_i(wr_data_i),
        .wr_addr_i(wr_ptr[ADDR_WIDTH-1:0]),
        .wr_i     (wr_req),
        .rd_clk_i (clk_i),
        .rd_addr_i(rd_ptr[ADDR_WIDTH-1:0]),
        .rd_i     (rd_en),
        .rd_data_o(rd_data_o)
    );
endmodule
